// File: rtl/alu_arbiter_ctrl.sv
// Round-robin front-end that shares one combinational ALU between requesters A and B.
// Illegal ops (mode>9, div/mod by zero) complete with err and never reach the ALU.
module alu_arbiter_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [N-1:0] a_in1,
  input  logic [N-1:0] a_in2,
  input  logic [3:0]   a_mode,
  input  logic [N-1:0] b_in1,
  input  logic [N-1:0] b_in2,
  input  logic [3:0]   b_mode,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [7:0]   res,
  output logic         res_neg,
  output logic         res_cero,
  output logic         res_carry,
  output logic         err,
  output logic         busy,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in2,
  output logic [3:0]   alu_mode,
  input  logic [7:0]   alu_num,
  input  logic         alu_neg,
  input  logic         alu_cero,
  input  logic         alu_carry
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic           last_b;
  logic           owner;
  logic           win_b;
  logic           illegal;
  logic           start;
  logic           reject;
  logic           capture;
  logic [N-1:0]   sel_in1, sel_in2;
  logic [3:0]     sel_mode;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // On a tie the requester that was not served last wins; last_b=1 means B was last.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    reject   = 1'b0;
    capture  = 1'b0;
    win_b    = (req == 2'b11) ? ~last_b : req[1];
    sel_in1  = win_b ? b_in1  : a_in1;
    sel_in2  = win_b ? b_in2  : a_in2;
    sel_mode = win_b ? b_mode : a_mode;
    illegal  = (sel_mode > 4'd9) ||
               (((sel_mode == 4'd8) || (sel_mode == 4'd9)) && (sel_in2 == '0));
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          if (illegal) begin
            reject  = 1'b1;
            state_n = DONE;
          end else begin
            start   = 1'b1;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == CW'(SETTLE - 1)) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      last_b    <= 1'b1;
      owner     <= 1'b0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      res       <= '0;
      res_neg   <= 1'b0;
      res_cero  <= 1'b0;
      res_carry <= 1'b0;
      err       <= 1'b0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_mode  <= '0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      if (state == RUN) cnt <= cnt + 1'b1;
      if (start) begin
        alu_in1  <= sel_in1;
        alu_in2  <= sel_in2;
        alu_mode <= sel_mode;
        owner    <= win_b;
        cnt      <= '0;
        gnt      <= win_b ? 2'b10 : 2'b01;
      end
      // Rejected ops leave alu_* untouched so the ALU never sees them.
      if (reject) begin
        owner     <= win_b;
        err       <= 1'b1;
        res       <= '0;
        res_neg   <= 1'b0;
        res_cero  <= 1'b0;
        res_carry <= 1'b0;
        done      <= win_b ? 2'b10 : 2'b01;
      end
      if (capture) begin
        res       <= alu_num;
        res_neg   <= alu_neg;
        res_cero  <= alu_cero;
        res_carry <= alu_carry;
        err       <= 1'b0;
        done      <= owner ? 2'b10 : 2'b01;
      end
      if (state == DONE) last_b <= owner;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Table-driven, scoreboard-checked bench for alu_arbiter_ctrl with a behavioural ALU stand-in.
module tb_alu_arbiter_ctrl;
  localparam int N      = 4;
  localparam int SETTLE = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] a_in1, a_in2, b_in1, b_in2;
  logic [3:0]   a_mode, b_mode;
  logic [1:0]   gnt, done;
  logic [7:0]   res;
  logic         res_neg, res_cero, res_carry, err, busy;
  logic [N-1:0] alu_in1, alu_in2;
  logic [3:0]   alu_mode;
  logic [7:0]   alu_num;
  logic         alu_neg, alu_cero, alu_carry;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_in1(a_in1), .a_in2(a_in2), .a_mode(a_mode),
    .b_in1(b_in1), .b_in2(b_in2), .b_mode(b_mode),
    .gnt(gnt), .done(done), .res(res),
    .res_neg(res_neg), .res_cero(res_cero), .res_carry(res_carry),
    .err(err), .busy(busy),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_num(alu_num), .alu_neg(alu_neg), .alu_cero(alu_cero), .alu_carry(alu_carry)
  );

  // Stand-in ALU: result is the raw 8-bit value, subtraction gives magnitude plus neg.
  logic [7:0] x, y;
  logic [8:0] sum9;
  always_comb begin
    x         = 8'(alu_in1);
    y         = 8'(alu_in2);
    sum9      = {1'b0, x} + {1'b0, y};
    alu_num   = '0;
    alu_neg   = 1'b0;
    alu_carry = 1'b0;
    case (alu_mode)
      4'd0: begin alu_num = sum9[7:0]; alu_carry = sum9[N]; end
      4'd1: begin
        if (x >= y) alu_num = x - y;
        else begin alu_num = y - x; alu_neg = 1'b1; end
      end
      4'd2: alu_num = x * y;
      4'd3: alu_num = x & y;
      4'd4: alu_num = x | y;
      4'd5: alu_num = x ^ y;
      4'd6: alu_num = 8'(~alu_in1);
      4'd7: alu_num = x << 1;
      4'd8: alu_num = (y != 0) ? x / y : 8'd0;
      4'd9: alu_num = (y != 0) ? x % y : 8'd0;
      default: alu_num = '0;
    endcase
    alu_cero = (alu_num == 8'd0);
  end

  typedef struct {
    logic       b;
    logic [3:0] in1, in2, mode;
    logic [7:0] res;
    logic       neg, cero, carry, err;
  } vec_t;

  vec_t       exp_done[$];
  logic [1:0] exp_gnt[$];
  vec_t       tbl[11];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       done_seen;

  function automatic vec_t mk(input logic b, input logic [3:0] i1, input logic [3:0] i2,
                              input logic [3:0] m, input logic [7:0] r, input logic n,
                              input logic c, input logic cy, input logic e);
    vec_t v;
    v.b = b; v.in1 = i1; v.in2 = i2; v.mode = m;
    v.res = r; v.neg = n; v.cero = c; v.carry = cy; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t e);
    chk("done", 32'(done), e.b ? 32'd2 : 32'd1);
    chk("res", 32'(res), 32'(e.res));
    chk("res_neg", 32'(res_neg), 32'(e.neg));
    chk("res_cero", 32'(res_cero), 32'(e.cero));
    chk("res_carry", 32'(res_carry), 32'(e.carry));
    chk("err", 32'(err), 32'(e.err));
  endtask

  task automatic checkReset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_flags", 32'({res_neg, res_cero, res_carry}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu", 32'({alu_in1, alu_in2, alu_mode}), 0);
  endtask

  // One clock step; every gnt/done pulse is matched against the scoreboard queues.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    done_seen = (done != 2'b00);
    if (gnt != 2'b00) begin
      if (exp_gnt.size() == 0) chk("unexpected_gnt", 32'(gnt), 0);
      else chk("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
    end
    if (done != 2'b00) begin
      if (exp_done.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin
        e = exp_done.pop_front();
        checkOutput(e);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int waited;
    if (v.b) begin b_in1 = v.in1; b_in2 = v.in2; b_mode = v.mode; req = 2'b10; end
    else     begin a_in1 = v.in1; a_in2 = v.in2; a_mode = v.mode; req = 2'b01; end
    exp_done.push_back(v);
    if (!v.err) exp_gnt.push_back(v.b ? 2'b10 : 2'b01);
    waited    = 0;
    done_seen = 1'b0;
    while (!done_seen && waited < 20) begin
      tick();
      waited++;
      // Operands changing after the grant must not affect the result.
      if (waited == 1 && !v.err) begin
        if (v.b) begin b_in1 = ~v.in1; b_in2 = ~v.in2; b_mode = 4'd3; end
        else     begin a_in1 = ~v.in1; a_in2 = ~v.in2; a_mode = 4'd3; end
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    else chk("latency", 32'(waited), v.err ? 32'd1 : 32'(SETTLE + 1));
    req = 2'b00;
  endtask

  initial begin
    vec_t last_ok;
    int   served, waited;
    tbl[0]  = mk(1'b0, 4'd3,  4'd5, 4'd0,  8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 4'd7,  4'd0, 4'd8,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(1'b1, 4'd9,  4'd4, 4'd8,  8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'd1,  4'd1, 4'd12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 4'd2,  4'd5, 4'd1,  8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 4'd15, 4'd1, 4'd0,  8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 4'd5,  4'd5, 4'd1,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 4'd7,  4'd3, 4'd9,  8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 4'd7,  4'd0, 4'd9,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 4'd0,  4'd0, 4'd10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 4'd15, 4'd15, 4'd2, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; req = 2'b00;
    a_in1 = '0; a_in2 = '0; a_mode = '0; b_in1 = '0; b_in2 = '0; b_mode = '0;
    repeat (2) @(negedge clk);
    checkReset();
    rst = 1'b0;

    // Both held high from reset: A wins the first tie, then strict alternation.
    a_in1 = 4'd4; a_in2 = 4'd3; a_mode = 4'd2;
    b_in1 = 4'd6; b_in2 = 4'd3; b_mode = 4'd5;
    for (int i = 0; i < 4; i++) begin
      exp_done.push_back(mk(i[0], 4'd0, 4'd0, 4'd0, i[0] ? 8'h05 : 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_gnt.push_back(i[0] ? 2'b10 : 2'b01);
    end
    req = 2'b11; served = 0; waited = 0;
    while (served < 4 && waited < 60) begin
      tick();
      waited++;
      if (done_seen) served++;
    end
    req = 2'b00;
    chk("fair_served", 32'(served), 4);
    tick();

    last_ok = tbl[0];
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i]);
      if (!tbl[i].err) last_ok = tbl[i];
      chk("alu_hold", 32'({alu_in1, alu_in2, alu_mode}),
          32'({last_ok.in1, last_ok.in2, last_ok.mode}));
      tick();
    end

    repeat (3) tick();
    chk("res_hold", 32'(res), 32'(tbl[10].res));
    chk("err_hold", 32'(err), 32'(tbl[10].err));

    // Reset in the middle of RUN aborts the op without a done pulse.
    a_in1 = 4'd7; a_in2 = 4'd7; a_mode = 4'd0; req = 2'b01;
    exp_gnt.push_back(2'b01);
    tick();
    req = 2'b00;
    tick();
    chk("busy_in_run", 32'(busy), 1);
    rst = 1'b1;
    tick();
    checkReset();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    applyStimulus(mk(1'b0, 4'd1, 4'd1, 4'd0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();

    chk("gnt_queue_empty", 32'(exp_gnt.size()), 0);
    chk("done_queue_empty", 32'(exp_done.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
